// File: rtl/game_pkg.sv
// Shared game definitions: action codes, facing codes, one-hot FSM states
// and the key priority encoder used by the control and character stages.
package game_pkg;

    // Action codes presented to the character stage
    localparam logic [2:0] NO_ACTION = 3'b000;
    localparam logic [2:0] ATTACK    = 3'b001;
    localparam logic [2:0] UP        = 3'b010;
    localparam logic [2:0] DOWN      = 3'b011;
    localparam logic [2:0] LEFT      = 3'b100;
    localparam logic [2:0] RIGHT     = 3'b101;

    // Facing codes kept by the character stage
    localparam logic [1:0] F_UP    = 2'b00;
    localparam logic [1:0] F_DOWN  = 2'b01;
    localparam logic [1:0] F_LEFT  = 2'b10;
    localparam logic [1:0] F_RIGHT = 2'b11;

    // Bit positions inside the 5-bit key vector
    localparam int K_RIGHT  = 0;
    localparam int K_LEFT   = 1;
    localparam int K_DOWN   = 2;
    localparam int K_UP     = 3;
    localparam int K_ATTACK = 4;

    // One-hot frame sequencing states
    typedef enum logic [4:0] {
        S_INIT      = 5'b00001,
        S_DRAW_MAP  = 5'b00010,
        S_DRAW_CHAR = 5'b00100,
        S_IDLE      = 5'b01000,
        S_APPLY     = 5'b10000
    } state_t;

    // Fixed priority: attack > up > down > left > right; opposing keys
    // simply fall out of the priority order.
    function automatic logic [2:0] encode_keys(input logic [4:0] k);
        if (k[K_ATTACK])     return ATTACK;
        else if (k[K_UP])    return UP;
        else if (k[K_DOWN])  return DOWN;
        else if (k[K_LEFT])  return LEFT;
        else if (k[K_RIGHT]) return RIGHT;
        else                 return NO_ACTION;
    endfunction

endpackage

// File: rtl/key_encoder.sv
// Two-flop synchronizer on the raw button levels followed by the
// priority encoder; output is the action for the synchronized keys.
module key_encoder (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] keys,
    output logic [2:0] action
);
    import game_pkg::*;

    logic [4:0] sync_1;
    logic [4:0] sync_2;

    // Metastability guard for asynchronous button inputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= keys;
            sync_2 <= sync_1;
        end
    end

    assign action = encode_keys(sync_2);

endmodule

// File: rtl/game_control.sv
// Frame sequencer: drives the map/character draw passes, converts the
// frame tick into one apply step per frame and latches the player action.
module game_control #(
    parameter int FRAME_DIV = 833333
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_attack,
    input  logic       map_draw_done,
    input  logic       char_draw_done,
    output logic       init,
    output logic       idle,
    output logic       apply_action,
    output logic       draw_map,
    output logic       draw_char,
    output logic [2:0] user_input,
    output logic       frame_overrun
);
    import game_pkg::*;

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    state_t           state, state_nxt;
    logic             rel_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             tick;
    logic             tick_pending;
    logic             enter_apply;
    logic [2:0]       action;
    logic [4:0]       keys;

    assign keys = {key_attack, key_up, key_down, key_left, key_right};

    key_encoder u_key_encoder (
        .clock  (clock),
        .resetn (resetn),
        .keys   (keys),
        .action (action)
    );

    // Reset-release flag: gates the strobes and holds S_INIT until the
    // first edge after release so init is visible for exactly one cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rel_q <= 1'b0;
        else         rel_q <= 1'b1;
    end

    // Free-running frame divider; the terminal count is the tick
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)   frame_cnt <= '0;
        else if (tick) frame_cnt <= '0;
        else           frame_cnt <= frame_cnt + 1'b1;
    end

    assign tick = (frame_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_INIT;
        else         state <= state_nxt;
    end

    // Next-state logic; done inputs only matter in their own state
    always_comb begin
        state_nxt   = state;
        enter_apply = 1'b0;
        case (state)
            S_INIT:      if (rel_q) state_nxt = S_DRAW_MAP;
            S_DRAW_MAP:  if (map_draw_done) state_nxt = S_DRAW_CHAR;
            S_DRAW_CHAR: if (char_draw_done) state_nxt = S_IDLE;
            S_IDLE: begin
                if (tick_pending) begin
                    state_nxt   = S_APPLY;
                    enter_apply = 1'b1;
                end
            end
            S_APPLY:     state_nxt = S_DRAW_MAP;
            default:     state_nxt = S_INIT;
        endcase
    end

    // Pending tick: cleared on entry to apply unless a fresh tick lands on
    // that same edge, in which case it carries over to the next frame
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)          tick_pending <= 1'b0;
        else if (enter_apply) tick_pending <= tick;
        else if (tick)        tick_pending <= 1'b1;
    end

    // Sticky overrun: a second tick merged into one still waiting
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                  frame_overrun <= 1'b0;
        else if (tick && tick_pending && !enter_apply) frame_overrun <= 1'b1;
    end

    // Action sampled once per frame, held until the next apply
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)          user_input <= NO_ACTION;
        else if (enter_apply) user_input <= action;
    end

    assign init         = rel_q & state[0];
    assign draw_map     = rel_q & state[1];
    assign draw_char    = rel_q & state[2];
    assign idle         = rel_q & state[3];
    assign apply_action = rel_q & state[4];

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with a 16-cycle frame.
module tb_game_control;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0;
    logic       key_right = 1'b0, key_attack = 1'b0;
    logic       map_draw_done = 1'b0, char_draw_done = 1'b0;
    logic       init, idle, apply_action, draw_map, draw_char;
    logic [2:0] user_input;
    logic       frame_overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // strobe vector {init, draw_map, draw_char, idle, apply_action}
    localparam logic [4:0] ST_NONE  = 5'b00000;
    localparam logic [4:0] ST_INIT  = 5'b10000;
    localparam logic [4:0] ST_MAP   = 5'b01000;
    localparam logic [4:0] ST_CHAR  = 5'b00100;
    localparam logic [4:0] ST_IDLE  = 5'b00010;
    localparam logic [4:0] ST_APPLY = 5'b00001;

    // key vectors {attack, up, down, left, right} and expected action
    logic [4:0] kv [7] = '{5'b01010, 5'b11010, 5'b01100, 5'b00011,
                           5'b00001, 5'b00100, 5'b00000};
    logic [2:0] ev [7] = '{3'b010, 3'b001, 3'b010, 3'b100,
                           3'b101, 3'b011, 3'b000};

    game_control #(.FRAME_DIV(16)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .key_up         (key_up),
        .key_down       (key_down),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_attack     (key_attack),
        .map_draw_done  (map_draw_done),
        .char_draw_done (char_draw_done),
        .init           (init),
        .idle           (idle),
        .apply_action   (apply_action),
        .draw_map       (draw_map),
        .draw_char      (draw_char),
        .user_input     (user_input),
        .frame_overrun  (frame_overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] strobes();
        return {init, draw_map, draw_char, idle, apply_action};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic set_keys(input logic [4:0] k);
        {key_attack, key_up, key_down, key_left, key_right} = k;
    endtask

    task automatic pulse_map();
        map_draw_done = 1'b1;
        step();
        map_draw_done = 1'b0;
    endtask

    task automatic pulse_char();
        char_draw_done = 1'b1;
        step();
        char_draw_done = 1'b0;
    endtask

    task automatic wait_apply(input int budget, output int at);
        int n;
        n = 0;
        while (!apply_action && n < budget) begin
            step();
            n++;
        end
        check("apply_seen", {31'd0, apply_action}, 32'd1);
        at = cyc;
    endtask

    initial begin
        int t_prev, t, napp;

        // held in reset
        resetn = 1'b0;
        repeat (3) step();
        check("rst_strobes", strobes(), ST_NONE);
        check("rst_user_input", user_input, 3'b000);
        check("rst_overrun", frame_overrun, 1'b0);

        // release: init for one cycle, then draw_map
        resetn = 1'b1;
        step();
        check("rel_init", strobes(), ST_INIT);
        check("rel_user_input", user_input, 3'b000);
        check("rel_overrun", frame_overrun, 1'b0);
        step();
        check("rel_map", strobes(), ST_MAP);

        // spurious char done in draw_map, then the normal sequence
        pulse_char();
        check("spur_char", strobes(), ST_MAP);
        pulse_map();
        check("map_to_char", strobes(), ST_CHAR);
        pulse_char();
        check("char_to_idle", strobes(), ST_IDLE);
        pulse_map();
        check("spur_map", strobes(), ST_IDLE);

        wait_apply(30, t_prev);
        check("apply_state", strobes(), ST_APPLY);
        step();
        check("apply_to_map", strobes(), ST_MAP);
        check("first_user_input", user_input, 3'b000);

        // one frame per key pattern; frame period must stay at 16
        for (int i = 0; i < 7; i++) begin
            set_keys(kv[i]);
            pulse_map();
            pulse_char();
            wait_apply(30, t);
            check($sformatf("period_%0d", i), t - t_prev, 16);
            check($sformatf("action_%0d", i), user_input, ev[i]);
            t_prev = t;
            step();
            check($sformatf("hold_%0d", i), user_input, ev[i]);
            check($sformatf("map_%0d", i), strobes(), ST_MAP);
        end
        check("no_overrun", frame_overrun, 1'b0);

        // overrun: character pass stalls across several ticks
        set_keys(5'b00001);
        pulse_map();
        repeat (40) step();
        check("ovr_char_held", strobes(), ST_CHAR);
        check("ovr_flag", frame_overrun, 1'b1);
        pulse_char();
        napp = 0;
        repeat (20) begin
            if (apply_action) napp++;
            step();
        end
        check("ovr_one_apply", napp, 1);
        check("ovr_sticky", frame_overrun, 1'b1);
        check("ovr_action", user_input, 3'b101);
        check("ovr_wait_map", strobes(), ST_MAP);

        // reset in the middle of the character pass
        pulse_map();
        check("mid_char", strobes(), ST_CHAR);
        resetn = 1'b0;
        set_keys(5'b00000);
        #1;
        check("mid_strobes", strobes(), ST_NONE);
        check("mid_user_input", user_input, 3'b000);
        check("mid_overrun", frame_overrun, 1'b0);
        step();
        step();
        resetn = 1'b1;
        step();
        check("mid_rel_init", strobes(), ST_INIT);
        check("mid_rel_user_input", user_input, 3'b000);
        step();
        check("mid_rel_map", strobes(), ST_MAP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
